// File: rtl/ram_pkg.sv
// Shared types and helpers for the multi-port RAM front end and its arbiter.
package ram_pkg;

  // Arbitration policy selector.
  typedef enum logic {
    ARB_RR    = 1'b0,  // round-robin, search starts after the last winner
    ARB_FIXED = 1'b1   // lowest requesting index always wins
  } arb_mode_e;

  // Upper bound on requester count; port indices are sized for this maximum.
  localparam int MAX_PORTS  = 8;
  localparam int PORT_IDX_W = 3;

  // One-stage response register: which port was granted, whether the access
  // was a read, and whether its address fell outside the valid range.
  typedef struct packed {
    logic                  valid;
    logic [PORT_IDX_W-1:0] idx;
    logic                  is_read;
    logic                  err;
  } rsp_reg_t;

  // Converts a one-hot (or zero) vector into the index of its set bit.
  function automatic logic [PORT_IDX_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    logic [PORT_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = idx | PORT_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-winner request arbiter, round-robin or fixed priority. The grant is
// combinational from the request vector and the stored last-winner pointer.
module rr_arbiter
  import ram_pkg::*;
#(
  parameter int        NPORTS   = 2,
  parameter arb_mode_e ARB_MODE = ARB_RR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NPORTS-1:0] req_i,
  output logic [NPORTS-1:0] gnt_o
);

  localparam int            LW       = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [LW-1:0] LAST_RST = LW'(NPORTS - 1);

  logic [LW-1:0] last_q;
  logic [LW-1:0] last_d;
  int            pidx;

  // Pick the first requester in search order and remember it as the new last winner.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    gnt_o  = '0;
    last_d = last_q;
    pidx   = 0;
    for (int i = 0; i < NPORTS; i++) begin
      if (ARB_MODE == ARB_RR) pidx = (int'(last_q) + 1 + i) % NPORTS;
      else                    pidx = i;
      if ((gnt_o == '0) && req_i[pidx]) begin
        gnt_o[pidx] = 1'b1;
        last_d      = LW'(pidx);
      end
    end
    // No grant may escape while the block is held in reset.
    if (!rst_n) begin
      gnt_o  = '0;
      last_d = last_q;
    end
  end

  // Last-winner pointer; only moves when a grant is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of block ordering.
    if (!rst_n) last_q <= LAST_RST;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Multi-port front end for a single-port synchronous RAM: arbitrates NPORTS
// requesters onto one memory port, returns read data one cycle after grant
// and flags out-of-range accesses with an error response.
module ram_port_arbiter
  import ram_pkg::*;
#(
  parameter int        NPORTS     = 2,
  parameter int        ADDR_WIDTH = 8,
  parameter int        DATA_WIDTH = 32,
  parameter int        DEPTH      = 1 << ADDR_WIDTH,
  parameter arb_mode_e ARB_MODE   = ARB_RR,
  parameter int        BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NPORTS-1:0]                    req_en,
  input  logic [NPORTS-1:0]                    req_we,
  input  logic [NPORTS-1:0][ADDR_WIDTH-1:0]    req_addr,
  input  logic [NPORTS-1:0][DATA_WIDTH-1:0]    req_wdata,
  input  logic [NPORTS-1:0][BE_WIDTH-1:0]      req_be,
  output logic [NPORTS-1:0]                    req_gnt,
  output logic [NPORTS-1:0]                    rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_rdata,
  output logic [NPORTS-1:0]                    rsp_err,
  output logic                                 mem_en,
  output logic [BE_WIDTH-1:0]                  mem_we,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  input  logic [DATA_WIDTH-1:0]                mem_rdata
);

  // Parameter sanity, rejected at elaboration.
  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("ram_port_arbiter: DATA_WIDTH must be a multiple of 8");
  end
  if (BE_WIDTH != DATA_WIDTH / 8) begin : g_bad_be_width
    $error("ram_port_arbiter: BE_WIDTH is derived and must equal DATA_WIDTH/8");
  end
  if ((DEPTH < 1) || (longint'(DEPTH) > (64'd1 << ADDR_WIDTH))) begin : g_bad_depth
    $error("ram_port_arbiter: DEPTH must lie in 1..2**ADDR_WIDTH");
  end
  if ((NPORTS < 1) || (NPORTS > MAX_PORTS)) begin : g_bad_nports
    $error("ram_port_arbiter: NPORTS must lie in 1..8");
  end

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam int              AW1       = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0]  DEPTH_LIM = AW1'(DEPTH);

  logic [NPORTS-1:0]     gnt;
  logic                  any_gnt;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BE_WIDTH-1:0]   sel_be;
  logic                  in_range;
  logic                  rsp_fire;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  rsp_reg_t              rsp_q;
  rsp_reg_t              rsp_d;

  rr_arbiter #(
    .NPORTS   (NPORTS),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_en),
    .gnt_o (gnt)
  );

  assign any_gnt = |gnt;
  assign req_gnt = gnt;

  // AND-OR multiplexer selecting the granted port's request fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (gnt[p]) begin
        sel_we    = req_we[p];
        sel_addr  = req_addr[p];
        sel_wdata = req_wdata[p];
        sel_be    = req_be[p];
      end
    end
    in_range = ({1'b0, sel_addr} < DEPTH_LIM);
  end

  // Drive the RAM port; out-of-range grants leave the RAM untouched.
  always_comb begin
    mem_en    = any_gnt && in_range;
    mem_we    = (mem_en && sel_we) ? sel_be : '0;
    mem_addr  = any_gnt ? sel_addr  : addr_q;
    mem_wdata = any_gnt ? sel_wdata : wdata_q;

    rsp_d         = '0;
    rsp_d.valid   = any_gnt;
    rsp_d.idx     = onehot_to_idx(MAX_PORTS'(gnt));
    rsp_d.is_read = !sel_we;
    rsp_d.err     = !in_range;
  end

  // Response register plus hold copies of the last address/data driven.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the hold registers are reset too, so mem_addr/mem_wdata never show X after reset even though their value is don't-care.
    if (!rst_n) begin
      rsp_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      rsp_q <= rsp_d;
      if (any_gnt) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
    end
  end

  // Decode the registered response onto per-port strobes and the shared data bus.
  always_comb begin
    rsp_fire  = rsp_q.valid && (rsp_q.is_read || rsp_q.err);
    rsp_valid = '0;
    rsp_err   = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (rsp_fire && (rsp_q.idx == PORT_IDX_W'(p))) begin
        rsp_valid[p] = 1'b1;
        rsp_err[p]   = rsp_q.err;
      end
    end
    rsp_rdata = (rsp_fire && rsp_q.is_read && !rsp_q.err) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: a round-robin instance driven against a behavioural
// RAM and a scoreboard model, plus a fixed-priority instance on the same
// request inputs whose grants are checked against lowest-index-wins.
module tb_ram_port_arbiter;
  import ram_pkg::*;

  localparam int NP    = 3;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 200;

  logic                   clk;
  logic                   rst_n;
  logic [NP-1:0]          req_en;
  logic [NP-1:0]          req_we;
  logic [NP-1:0][AW-1:0]  req_addr;
  logic [NP-1:0][DW-1:0]  req_wdata;
  logic [NP-1:0][BW-1:0]  req_be;

  logic [NP-1:0] gnt_rr, rsp_valid_rr, rsp_err_rr;
  logic [DW-1:0] rsp_rdata_rr, mem_wdata_rr, mem_rdata_rr;
  logic          mem_en_rr;
  logic [BW-1:0] mem_we_rr;
  logic [AW-1:0] mem_addr_rr;

  logic [NP-1:0] gnt_fx, rsp_valid_fx, rsp_err_fx;
  logic [DW-1:0] rsp_rdata_fx, mem_wdata_fx, mem_rdata_fx;
  logic          mem_en_fx;
  logic [BW-1:0] mem_we_fx;
  logic [AW-1:0] mem_addr_fx;

  ram_port_arbiter #(.NPORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ARB_MODE(ARB_RR)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_en(req_en), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_gnt(gnt_rr), .rsp_valid(rsp_valid_rr),
    .rsp_rdata(rsp_rdata_rr), .rsp_err(rsp_err_rr), .mem_en(mem_en_rr), .mem_we(mem_we_rr),
    .mem_addr(mem_addr_rr), .mem_wdata(mem_wdata_rr), .mem_rdata(mem_rdata_rr)
  );

  ram_port_arbiter #(.NPORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .rst_n(rst_n), .req_en(req_en), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_gnt(gnt_fx), .rsp_valid(rsp_valid_fx),
    .rsp_rdata(rsp_rdata_fx), .rsp_err(rsp_err_fx), .mem_en(mem_en_fx), .mem_we(mem_we_fx),
    .mem_addr(mem_addr_fx), .mem_wdata(mem_wdata_fx), .mem_rdata(mem_rdata_fx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port RAM behind the round-robin instance.
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_en_rr) begin
      if (mem_we_rr == '0) mem_rdata_rr <= ram[mem_addr_rr];
      else begin
        for (int b = 0; b < BW; b++)
          if (mem_we_rr[b]) ram[mem_addr_rr][8*b +: 8] <= mem_wdata_rr[8*b +: 8];
      end
    end
  end
  assign mem_rdata_fx = '0;

  // Scoreboard state.
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] mdl [0:DEPTH-1];
  int            mptr;       // last granted port of the round-robin model
  logic [NP-1:0] exp_v;      // expected response strobes next cycle
  logic [NP-1:0] exp_e;
  logic [DW-1:0] exp_d;
  int            cur_g;      // port the model granted in the latest step (-1 none)
  logic [DW-1:0] cap_rdata;  // rsp_rdata seen in the latest step
  logic [NP-1:0] cap_err;
  logic [NP-1:0] cap_gnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_rr_pick(input logic [NP-1:0] en, input int last);
    for (int k = 1; k <= NP; k++) if (en[(last + k) % NP]) return (last + k) % NP;
    return -1;
  endfunction

  function automatic logic [NP-1:0] lowest_bit(input logic [NP-1:0] en);
    for (int k = 0; k < NP; k++) if (en[k]) return NP'(1) << k;
    return '0;
  endfunction

  task automatic model_reset();
    mptr  = NP - 1;
    exp_v = '0;
    exp_e = '0;
    exp_d = '0;
  endtask

  // One clock cycle: inputs already driven; check at negedge, then advance.
  task automatic step();
    int            g;
    logic [AW-1:0] a;
    logic          inr;
    @(negedge clk);
    check("rsp_valid", 64'(rsp_valid_rr), 64'(exp_v));
    check("rsp_err",   64'(rsp_err_rr),   64'(exp_e));
    if (exp_v != '0) check("rsp_rdata", 64'(rsp_rdata_rr), 64'(exp_d));
    cap_rdata = rsp_rdata_rr;
    cap_err   = rsp_err_rr;
    cap_gnt   = gnt_rr;

    check("gnt_fixed", 64'(gnt_fx), 64'(lowest_bit(req_en)));
    g = model_rr_pick(req_en, mptr);
    cur_g = g;
    exp_v = '0;
    exp_e = '0;
    exp_d = '0;
    if (g < 0) begin
      check("gnt_rr_idle", 64'(gnt_rr), 64'd0);
      check("mem_en_idle", 64'(mem_en_rr), 64'd0);
      check("mem_we_idle", 64'(mem_we_rr), 64'd0);
    end else begin
      a   = req_addr[g];
      inr = (int'(a) < DEPTH);
      check("gnt_rr", 64'(gnt_rr), 64'(NP'(1) << g));
      check("mem_en", 64'(mem_en_rr), 64'(inr));
      check("mem_we", 64'(mem_we_rr), 64'((inr && req_we[g]) ? req_be[g] : '0));
      if (inr) begin
        check("mem_addr", 64'(mem_addr_rr), 64'(a));
        if (req_we[g]) check("mem_wdata", 64'(mem_wdata_rr), 64'(req_wdata[g]));
      end
      if (!inr) begin
        exp_v[g] = 1'b1;
        exp_e[g] = 1'b1;
      end else if (!req_we[g]) begin
        exp_v[g] = 1'b1;
        exp_d    = mdl[a];
      end else begin
        for (int b = 0; b < BW; b++)
          if (req_be[g][b]) mdl[a][8*b +: 8] = req_wdata[g][8*b +: 8];
      end
      mptr = g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
    req_en[p]    = 1'b1;
    req_we[p]    = we;
    req_addr[p]  = a;
    req_wdata[p] = d;
    req_be[p]    = be;
  endtask

  initial begin
    logic [NP-1:0] held;
    for (int i = 0; i < 256; i++) ram[i] = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    mem_rdata_rr = '0;
    req_en = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    model_reset();
    cur_g = -1;

    // Reset with every port requesting: nothing may be granted or driven.
    rst_n  = 1'b0;
    req_en = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt",       64'(gnt_rr),       64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_rr), 64'd0);
    check("rst_rsp_err",   64'(rsp_err_rr),   64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata_rr), 64'd0);
    check("rst_mem_en",    64'(mem_en_rr),    64'd0);
    check("rst_mem_we",    64'(mem_we_rr),    64'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    req_en = '0;

    // Full write then read back on port 0.
    set_req(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF); step();
    req_en = '0; set_req(0, 1'b0, 8'h10, 32'h0, 4'h0); step();
    req_en = '0; step();
    check("read_full", 64'(cap_rdata), 64'h0000_0000_DEAD_BEEF);

    // Partial write of byte 1 only, then read back.
    set_req(0, 1'b1, 8'h10, 32'h0000AA00, 4'b0010); step();
    req_en = '0; set_req(0, 1'b0, 8'h10, 32'h0, 4'h0); step();
    req_en = '0; step();
    check("read_partial", 64'(cap_rdata), 64'h0000_0000_DEAD_AAEF);

    // Write with no byte enables: RAM enabled, nothing written, no response.
    set_req(1, 1'b1, 8'h10, 32'h12345678, 4'h0); step();
    req_en = '0; step();

    // Out-of-range read on port 2, then boundary addresses 199 and 200.
    set_req(2, 1'b0, 8'd250, 32'h0, 4'h0); step();
    req_en = '0; step();
    check("oor_err_port", 64'(cap_err), 64'b100);
    set_req(0, 1'b0, 8'd199, 32'h0, 4'h0); step();
    req_en = '0; set_req(2, 1'b1, 8'd200, 32'hCAFEF00D, 4'hF); step();
    req_en = '0; step();

    // Back-to-back reads from ports 0 and 1.
    set_req(0, 1'b1, 8'h20, 32'h11112222, 4'hF); step();
    req_en = '0; set_req(1, 1'b1, 8'h21, 32'h33334444, 4'hF); step();
    req_en = '0; set_req(0, 1'b0, 8'h20, 32'h0, 4'h0); step();
    req_en = '0; set_req(1, 1'b0, 8'h21, 32'h0, 4'h0); step();
    req_en = '0; step();
    check("b2b_second_data", 64'(cap_rdata), 64'h0000_0000_3333_4444);

    // Reset asserted in the cycle after a read grant: the response is dropped.
    set_req(1, 1'b0, 8'h20, 32'h0, 4'h0); step();
    rst_n  = 1'b0;
    req_en = '1;
    @(negedge clk);
    check("midrst_rsp_valid", 64'(rsp_valid_rr), 64'd0);
    check("midrst_gnt",       64'(gnt_rr),       64'd0);
    check("midrst_mem_en",    64'(mem_en_rr),    64'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Round-robin fairness with all three ports requesting continuously.
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, AW'(8'h20 + p), 32'h0, 4'h0);
    for (int c = 0; c < 6; c++) begin
      step();
      check("rr_order", 64'(cap_gnt), 64'(NP'(1) << (c % NP)));
    end
    req_en = '0; step();

    // Randomised traffic obeying the hold-until-granted rule.
    held = '0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (held[p]) begin
          if ($urandom_range(0, 15) == 0) req_en[p] = 1'b0;
        end else if ($urandom_range(0, 2) != 0) begin
          set_req(p, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 8) ? AW'($urandom_range(0, DEPTH - 1))
                                             : AW'($urandom_range(DEPTH, 255)),
                  $urandom, BW'($urandom_range(0, 15)));
        end else begin
          req_en[p] = 1'b0;
        end
      end
      step();
      held = req_en;
      if (cur_g >= 0) held[cur_g] = 1'b0;
    end
    req_en = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Parametrised multi-port front end for the single-port synchronous RAM. It accepts up to NPORTS independent CPU-side requesters with byte-enabled writes and arbitrates them onto one memory port, round-robin or fixed-priority. It returns read data with one-cycle latency and flags out-of-range accesses. It sits between the core/DMA masters and the RAM macro, replacing direct single-master wiring.

## Interface
- NPORTS, 2: number of requester ports (1..8).
- ADDR_WIDTH, 8: address width, in words.
- DATA_WIDTH, 32: data width; must be a multiple of 8.
- DEPTH, 1 << ADDR_WIDTH: number of valid words; DEPTH ≤ 2^ADDR_WIDTH.
- ARB_MODE, ARB_RR: ARB_RR (round-robin) or ARB_FIXED (lowest index wins).
- BE_WIDTH, DATA_WIDTH/8: derived; not to be overridden.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_en  in  [NPORTS]  request valid per port; held until granted.
- req_we  in  [NPORTS]  1 = write, 0 = read.
- req_addr  in  [NPORTS][ADDR_WIDTH]  word address.
- req_wdata  in  [NPORTS][DATA_WIDTH]  write data.
- req_be  in  [NPORTS][BE_WIDTH]  byte enables; ignored for reads.
- req_gnt  out  [NPORTS]  one-hot or zero; request accepted this cycle.
- rsp_valid  out  [NPORTS]  read data / error valid, one cycle after grant.
- rsp_rdata  out  [DATA_WIDTH]  shared read data bus, qualified by rsp_valid.
- rsp_err  out  [NPORTS]  access out of range; pulses with the response.
- mem_en  out  1  RAM enable.
- mem_we  out  [BE_WIDTH]  per-byte write enable.
- mem_addr  out  [ADDR_WIDTH]  RAM address.
- mem_wdata  out  [DATA_WIDTH]  RAM write data.
- mem_rdata  in  [DATA_WIDTH]  RAM read data, valid the cycle after mem_en with mem_we == 0.

## Operation
- Grant is combinational from req_en and the priority pointer. At most one port is granted per cycle; a grant is issued whenever any req_en is high.
- ARB_RR: search starts at (last_gnt + 1) mod NPORTS. last_gnt updates only on a grant. Reset value is NPORTS-1, so port 0 wins first.
- ARB_FIXED: lowest set index wins. last_gnt is unused.
- Granted in-range request: mem_en=1, mem_addr=req_addr, mem_wdata=req_wdata, mem_we = req_we ? req_be : '0.
- A write with req_be == 0 is still granted and drives mem_en=1 with mem_we=0. No response is produced.
- Out of range (req_addr ≥ DEPTH): the request is granted but mem_en=0. Next cycle, rsp_valid and rsp_err pulse for that port (reads and writes), and rsp_rdata=0.
- Reads: a one-stage response register captures {port index, is_read, err}. The next cycle, rsp_valid[port]=1 and rsp_rdata=mem_rdata (or 0 on error).
- Writes in range produce no response.
- Back-to-back grants every cycle are supported. The response for grant N coincides with the memory access for grant N+1.
- No request: mem_en=0, mem_we=0. mem_addr and mem_wdata hold their last values (don't-care).

## Timing
- Read latency: grant at cycle t, rsp_valid at t+1, exactly one cycle wide.
- Throughput: 1 access/cycle aggregate. In RR mode, each continuously requesting port is served at least once every NPORTS cycles.
- Reset values: req_gnt=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_en=0, mem_we=0, last_gnt=NPORTS-1.
- While rst_n is low, req_gnt is forced to 0 regardless of req_en.
- Reset asserted between grant and response: the pending response is discarded, and rsp_valid stays 0 after release.
- Requester rule: req_* must stay stable while req_en=1 and req_gnt=0. Dropping req_en before grant is permitted, and no response results.

## Structure
- Package ram_pkg holds:
  - the arb_mode_e typedef (ARB_RR, ARB_FIXED);
  - the response-register struct {port idx [$clog2(NPORTS)], is_read, err};
  - an onehot-to-index function.
- Sub-module rr_arbiter(NPORTS, ARB_MODE): req vector in, one-hot gnt out, holds last_gnt. Reusable for future bus arbiters.
- Elaboration assertions: DATA_WIDTH % 8 == 0, DEPTH ≤ 2^ADDR_WIDTH, 1 ≤ NPORTS ≤ 8.

## Test plan
- Reset, then port 0 writes 0xDEADBEEF to addr 0x10 with be=4'hF; port 0 reads addr 0x10. Expect rsp_valid[0] one cycle after grant, rsp_rdata=0xDEADBEEF.
- Partial write: be=4'b0010, wdata=0x0000AA00 to addr 0x10. Read back returns 0xDEADAAEF.
- RR fairness, NPORTS=3, all ports requesting continuously for 6 cycles. Grant order is 0,1,2,0,1,2. ARB_FIXED with the same stimulus grants 0 every cycle.
- DEPTH=200, read addr 250. Expect grant, mem_en=0, then rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Back-to-back reads from ports 0 and 1 on consecutive cycles. Expect two consecutive one-cycle rsp_valid pulses on the correct ports with the correct data.
- Assert rst_n low in the cycle after a read grant. Expect no rsp_valid. After release, port 0 wins first.
